// File: rtl/add16_seq_if.sv
// add16_seq_if: operand/result bundle between a control unit and the add16_seq sequencer.
//
// Signals:
//   start    - request; the sequencer accepts it only when idle or finishing
//   op_sub   - 0 = a+b, 1 = a-b; sampled with start
//   a, b     - operands (W = 4*NIBBLES bits); sampled with start
//   busy     - operation in progress
//   done     - one-cycle pulse, result and flags valid
//   result   - sum/difference, held until the next completion
//   c_out    - carry out of the MSB (subtract: 1 = no borrow)
//   overflow - signed two's-complement overflow
//   zero     - result == 0
//
// Modports: master = requester (control unit), slave = the sequencer.

interface add16_seq_if #(
   parameter int unsigned NIBBLES = 4
);
   localparam int unsigned W = 4 * NIBBLES;

   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         c_out;
   logic         overflow;
   logic         zero;

   modport master (
      output start, op_sub, a, b,
      input  busy, done, result, c_out, overflow, zero
   );

   modport slave (
      input  start, op_sub, a, b,
      output busy, done, result, c_out, overflow, zero
   );
endinterface

// File: rtl/add16_seq.sv
// add16_seq: multi-cycle add/subtract sequencer. One 4-bit adder slice is reused across the
// NIBBLES nibbles of the operands, least-significant nibble first, so a W-bit operation takes
// NIBBLES cycles in RUN followed by a single DONE cycle.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous reset, active-high; aborts any in-flight operation
//   bus_io - add16_seq_if slave: start/op_sub/a/b in, busy/done/result/flags out

module add16_seq #(
   parameter int unsigned NIBBLES = 4
) (
   input logic        clk,
   input logic        rst,
   add16_seq_if.slave bus_io
);
   localparam int unsigned W       = 4 * NIBBLES;
   localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [W-1:0]    a_q;
   logic [W-1:0]    b_q;      // effective operand: already inverted for subtract
   logic [W-1:0]    acc_q;
   logic            carry_q;
   logic            busy_q;
   logic            done_q;
   logic [W-1:0]    result_q;
   logic            c_out_q;
   logic            ovf_q;
   logic            zero_q;

   // Shared 4-bit slice and the accumulator as it will look after this cycle's nibble.
   logic [3:0]   nib_a;
   logic [3:0]   nib_b;
   logic [4:0]   nib_sum;
   logic [W-1:0] acc_d;
   logic         ovf_d;

   always_comb begin
      nib_a   = a_q[{cnt_q, 2'b00} +: 4];
      nib_b   = b_q[{cnt_q, 2'b00} +: 4];
      nib_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
      acc_d   = acc_q;
      acc_d[{cnt_q, 2'b00} +: 4] = nib_sum[3:0];
      // Only meaningful on the last nibble, when acc_d holds the full sum.
      ovf_d   = (a_q[W-1] == b_q[W-1]) && (acc_d[W-1] != a_q[W-1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         c_out_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               done_q <= 1'b0;
               if (bus_io.start) begin
                  a_q     <= bus_io.a;
                  b_q     <= bus_io.op_sub ? ~bus_io.b : bus_io.b;
                  // Carry-in supplies the +1 of the two's complement negation.
                  carry_q <= bus_io.op_sub;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               acc_q   <= acc_d;
               carry_q <= nib_sum[4];
               if (cnt_q == CntLast) begin
                  result_q <= acc_d;
                  c_out_q  <= nib_sum[4];
                  ovf_q    <= ovf_d;
                  zero_q   <= (acc_d == '0);
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= StDone;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus_io.busy     = busy_q;
   assign bus_io.done     = done_q;
   assign bus_io.result   = result_q;
   assign bus_io.c_out    = c_out_q;
   assign bus_io.overflow = ovf_q;
   assign bus_io.zero     = zero_q;

endmodule

// File: tb/tb_add16_seq.sv
// tb_add16_seq: scoreboard bench for add16_seq. The driver pushes the expected response for
// every accepted request; an independent monitor pops and compares on each done pulse and
// checks that result/flags hold steady between completions.

module tb_add16_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   add16_seq_if #(.NIBBLES(4)) bus ();

   add16_seq #(.NIBBLES(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   typedef struct packed {
      logic [15:0] res;
      logic        c;
      logic        o;
      logic        z;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] res, input logic c, input logic o,
                               input logic z);
      exp_t e;
      e.res = res;
      e.c   = c;
      e.o   = o;
      e.z   = z;
      return e;
   endfunction

   // Reference: plain integer arithmetic on signed and unsigned interpretations.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
      int   sa;
      int   sb;
      int   sx;
      int   ua;
      int   ub;
      int   ux;
      exp_t e;
      sa = int'($signed(a));
      sb = int'($signed(b));
      ua = int'({16'h0, a});
      ub = int'({16'h0, b});
      sx = sub ? sa - sb : sa + sb;
      ux = sub ? ua - ub : ua + ub;
      e.res = ux[15:0];
      e.c   = sub ? (ua >= ub) : (ux > 65535);
      e.o   = (sx > 32767) || (sx < -32768);
      e.z   = (e.res == 16'h0000);
      return e;
   endfunction

   // Caller is just past a negedge; start is sampled at the next posedge.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input exp_t e, input bit push);
      bus.a      = a;
      bus.b      = b;
      bus.op_sub = sub;
      bus.start  = 1'b1;
      if (push) sb_q.push_back(e);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      // Scramble operands: they must not matter after acceptance.
      bus.a      = 16'($urandom);
      bus.b      = 16'($urandom);
      bus.op_sub = 1'($urandom);
   endtask

   // Counts negedges until done is seen (bounded); leaves us at that negedge.
   task automatic wait_done(output int lat, output int busy_n);
      bit seen;
      seen   = 1'b0;
      lat    = 0;
      busy_n = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         lat++;
         if (bus.busy) busy_n++;
         if (bus.done) seen = 1'b1;
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                     input exp_t e, input bit b2b);
      int lat;
      int bn;
      if (!b2b) begin
         @(negedge clk);
         check("idle_done_low", 32'(bus.done), 32'd0);
         check("idle_busy_low", 32'(bus.busy), 32'd0);
      end
      issue(a, b, sub, e, 1'b1);
      wait_done(lat, bn);
      check("done_latency", 32'(lat), 32'd5);
      check("busy_cycles", 32'(bn), 32'd4);
   endtask

   // Monitor / scoreboard.
   exp_t held;
   initial begin
      exp_t e;
      held = '0;
      forever begin
         @(posedge clk);
         if (rst) held = '0;
         @(negedge clk);
         if (!rst) begin
            if (bus.done) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_done", 32'(bus.done), 32'd0);
               end else begin
                  e = sb_q.pop_front();
                  check("result", 32'(bus.result), 32'(e.res));
                  check("c_out", 32'(bus.c_out), 32'(e.c));
                  check("overflow", 32'(bus.overflow), 32'(e.o));
                  check("zero", 32'(bus.zero), 32'(e.z));
                  check("busy_in_done", 32'(bus.busy), 32'd0);
                  held = e;
               end
            end else begin
               check("result_hold", 32'({bus.result, bus.c_out, bus.overflow, bus.zero}),
                     32'(held));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         bn;
      bit         seen;
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      logic [15:0] edge_v [4];

      edge_v[0] = 16'h0000;
      edge_v[1] = 16'hFFFF;
      edge_v[2] = 16'h8000;
      edge_v[3] = 16'h7FFF;

      bus.start  = 1'b0;
      bus.op_sub = 1'b0;
      bus.a      = '0;
      bus.b      = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_flags", 32'({bus.c_out, bus.overflow, bus.zero}), 32'd0);

      // Directed vectors with hand-computed expectations.
      op(16'h1234, 16'h0FFF, 1'b0, mk(16'h2233, 1'b0, 1'b0, 1'b0), 1'b0);
      op(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1), 1'b0);
      op(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0), 1'b0);
      op(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0), 1'b0);
      op(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 1'b0), 1'b0);
      op(16'h0007, 16'h0007, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1), 1'b0);

      // start during RUN is ignored; start during DONE is accepted back-to-back.
      @(negedge clk);
      issue(16'h0001, 16'h0001, 1'b0, mk(16'h0002, 1'b0, 1'b0, 1'b0), 1'b1);
      @(negedge clk);
      @(negedge clk);
      bus.a      = 16'hAAAA;
      bus.b      = 16'h5555;
      bus.op_sub = 1'b0;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_done(lat, bn);
      check("ignored_start_latency", 32'(lat), 32'd3);
      op(16'h0100, 16'h0200, 1'b0, mk(16'h0300, 1'b0, 1'b0, 1'b0), 1'b1);

      // Reset mid-RUN aborts without a done pulse.
      @(negedge clk);
      issue(16'h1234, 16'h1111, 1'b0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_result", 32'(bus.result), 32'd0);
      check("abort_flags", 32'({bus.c_out, bus.overflow, bus.zero}), 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      op(16'h0003, 16'h0004, 1'b0, mk(16'h0007, 1'b0, 1'b0, 1'b0), 1'b0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 60; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) begin
            op(ra, rb, rs, model(ra, rb, rs), 1'b1);
         end else begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op(ra, rb, rs, model(ra, rb, rs), 1'b0);
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/add16_seq.md
Name: add16_seq

Overview:
- Multi-cycle 16-bit add/subtract sequencer for the MIPS-16 datapath.
- Time-shares one instance of the team's existing 4-bit full adder slice (FA_4bit) across the four nibbles of the operands, least-significant nibble first.
- Used where a full 16-bit ripple adder is too costly (e.g. address/branch offset unit); provides a start/busy/done handshake to the control unit.

Parameters:
NIBBLES, 4, number of 4-bit slices processed; operand width W = 4*NIBBLES (16 by default).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; accepted only in IDLE or DONE
op_sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse, result/flags valid
result  output  W  sum/difference; held until next completion
c_out  output  1  carry out of MSB (subtract: 1 = no borrow)
overflow  output  1  signed two's-complement overflow
zero  output  1  result == 0

Behaviour:
- Reset is synchronous and active-high on rst, single clock clk.
- Reset drives:
  - state to IDLE;
  - busy, done, c_out, overflow, zero to 0;
  - result to 0;
  - nibble counter and internal operand/accumulator registers to 0.
- States: IDLE, RUN, DONE.
- Accepting a start (start=1 at an edge while in IDLE or DONE):
  - latch a_r = a;
  - latch b_r = op_sub ? ~b : b;
  - set carry_r = op_sub (this gives the +1 of two's complement);
  - set cnt = 0;
  - go to RUN.
- RUN, each cycle:
  - adder inputs are a_r[4*cnt+3:4*cnt], b_r[same], and carry_r.
  - at the edge: store the adder sum into acc[4*cnt+3:4*cnt], set carry_r = adder carry out, then cnt++.
  - when cnt == NIBBLES-1 at the edge, go to DONE and, on that same edge:
    - result = final acc (including the nibble just computed);
    - c_out = final carry;
    - overflow = (a_r[W-1] == b_r[W-1]) && (sum[W-1] != a_r[W-1]), with the effective (possibly inverted) b;
    - zero = (final result == 0).
- result and flags never change except on that completing edge or on reset. No partial results are visible.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - next state is RUN if start=1 (back-to-back accept, same latch rules as IDLE), otherwise IDLE.
- busy = 1 exactly while in RUN; done = 1 exactly while in DONE.
- Latency:
  - start sampled at edge E0;
  - RUN occupies the NIBBLES cycles after E0;
  - DONE is entered at edge E(NIBBLES), so done is high in the cycle after E(NIBBLES), i.e. 4 cycles after acceptance by default.
  - Throughput is one operation per NIBBLES+1 cycles.
- start while in RUN is ignored: no queuing, operands are not re-sampled, and the in-flight operation is unaffected.
- Changing a, b or op_sub after acceptance has no effect.
- rst=1 in any state, including mid-RUN:
  - the operation is aborted and no done pulse is issued;
  - all outputs are forced to their reset values on that edge.
- rst has priority over start in the same cycle.
- Arithmetic is modulo 2^W; c_out is the carry out of the MSB nibble.
- cnt width is ceil(log2(NIBBLES)), minimum 1; the counter never wraps past NIBBLES-1 within an operation.

Test Plan:
- Reset, then add 0x1234 + 0x0FFF -> done exactly 4 cycles after the start edge; result=0x2233, c_out=0, overflow=0, zero=0; busy high for 4 cycles, done high for 1.
- Add 0xFFFF + 0x0001 -> result=0x0000, c_out=1, zero=1, overflow=0.
- Add 0x7FFF + 0x0001 -> result=0x8000, overflow=1, c_out=0. Then subtract 0x8000 - 0x0001 -> result=0x7FFF, overflow=1, c_out=1.
- Subtract 0x0005 - 0x0007 -> result=0xFFFE, c_out=0 (borrow), overflow=0. Subtract 0x0007 - 0x0007 -> result=0x0000, zero=1, c_out=1.
- Start 0x0001+0x0001, then pulse start with 0xAAAA+0x5555 on the second RUN cycle, then again in the DONE cycle with 0x0100+0x0200 -> first done gives 0x0002; the RUN-time start is ignored; the DONE-time start is accepted back-to-back, busy rises next cycle, and 4 cycles later result=0x0300.
- Start 0x1234+0x1111, assert rst on the 2nd RUN cycle -> no done pulse ever; busy=0, result=0x0000, flags 0 after the reset edge. A following start of 0x0003+0x0004 completes normally with result=0x0007.
